nf10_bridge_input_arbiter: RTL and testbench
============================================

// Module: nf10_bridge_input_arbiter
// PURPOSE
//  Packet-granular round-robin arbiter sharing one LE->BE bridge instance among NUM_QUEUES AXI4-Stream sources.
//  Sits in front of the bridge's s_axis port and grants one whole packet (tlast-delimited) at a time.
//  Output side uses a registered 2-entry skid slice, so no combinational path exists from m_axis_tready to any s_axis_tready.
// PARAMETERS
//  C_AXIS_DATA_WIDTH   256  tdata width per stream; tstrb width is C_AXIS_DATA_WIDTH/8
//  C_AXIS_TUSER_WIDTH  128  tuser width per stream
//  NUM_QUEUES          4    number of requesters; legal range 2..8
// PORTS
//  clk            in   1                        single clock for the whole block
//  reset          in   1                        synchronous, active-high
//  s_axis_tdata   in   NUM_QUEUES*DATA          flattened; queue i at [i*DATA +: DATA]
//  s_axis_tstrb   in   NUM_QUEUES*DATA/8        flattened, same ordering as tdata
//  s_axis_tuser   in   NUM_QUEUES*TUSER         flattened, same ordering as tdata
//  s_axis_tvalid  in   NUM_QUEUES               per-queue valid
//  s_axis_tlast   in   NUM_QUEUES               per-queue last
//  s_axis_tready  out  NUM_QUEUES               per-queue ready
//  m_axis_tdata   out  DATA                     to bridge s_axis_tdata
//  m_axis_tstrb   out  DATA/8                   to bridge s_axis_tstrb
//  m_axis_tuser   out  TUSER                    to bridge s_axis_tuser
//  m_axis_tvalid  out  1                        to bridge s_axis_tvalid
//  m_axis_tlast   out  1                        to bridge s_axis_tlast
//  m_axis_tready  in   1                        from bridge s_axis_tready
//  grant_id       out  clog2(NUM_QUEUES)        queue currently owning the output
// BEHAVIOUR
//  - Reset values: s_axis_tready=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata/tstrb/tuser=0, grant_id=0.
//    Internal: state=IDLE, rr_ptr=NUM_QUEUES-1, slice empty.
//  - FSM IDLE: if any s_axis_tvalid is set, pick the first valid queue scanning rr_ptr+1, rr_ptr+2, ... (mod NUM_QUEUES).
//    Register the pick into grant_id, go to PKT. One-cycle arbitration bubble; s_axis_tready is 0 while in IDLE.
//  - FSM PKT: s_axis_tready[grant_id] = slice_can_accept; all other ready bits are 0.
//    Each beat with tvalid&tready on grant_id is written into the slice unchanged.
//    A beat with tlast that transfers: rr_ptr<=grant_id, go to IDLE.
//  - Skid slice: 2 entries; slice_can_accept is registered and means fewer than 2 entries held.
//    m_axis_tvalid is asserted iff the slice is non-empty; an entry pops on m_axis_tvalid&m_axis_tready.
//    Latency: input beat to m_axis is 1 cycle. Full throughput of 1 beat/cycle inside a packet.
//  - Beats are never dropped, duplicated or reordered; tdata/tstrb/tuser/tlast pass through bit-exact.
//  - No interleaving: the output never carries beats of two queues between consecutive tlasts.
//  - Single-beat packets: grant, 1 beat, back to IDLE. The bubble caps throughput at 1 packet per 2 cycles.
//  - m_axis_tready held low: the slice fills (2 beats), then s_axis_tready drops; the granted queue is held indefinitely. No timeout.
//  - A source deasserting tvalid mid-packet keeps the grant; the FSM waits in PKT.
//  - Reset mid-packet: everything returns to reset values at the next edge; slice contents are discarded.
//    The partial packet is not completed; the downstream bridge is reset by the same signal.
//  - rr_ptr width clog2(NUM_QUEUES); wrap from NUM_QUEUES-1 to 0 is explicit (no reliance on power-of-2).
// CONFIGURATION
//  - Macro NF10_BRIDGE_ARB_STATS_EN.
//    Defined: adds output pkt_count [NUM_QUEUES*32-1:0], one 32-bit counter per queue (queue i at [i*32 +: 32]).
//    Each counter increments on an accepted input tlast beat of that queue, wraps 2^32-1 -> 0, and resets to 0.
//    Undefined: the port and counters do not exist; all other behaviour is identical.
// STRUCTURE
//  - Shared include nf10_bridge_arb_defs.vh: FSM encodings ARB_IDLE=1'b0, ARB_PKT=1'b1, and a clog2 function.
//  - Sub-module nf10_axis_skid_slice (params DATA, TUSER): 2-entry registered slice, reusable on the bridge's m_axis side.
//  - Top holds the FSM, round-robin pointer, input mux and optional counters.
// TESTING
//  1. Reset, then q0 sends a 3-beat packet with m_axis_tready=1 -> grant_id=0 one cycle after tvalid; 3 beats on m_axis bit-exact, tlast on beat 3.
//  2. All 4 queues hold 2-beat packets at once -> output packet order q0,q1,q2,q3, then q0 again; never interleaved.
//  3. q1 active with m_axis_tready=0 for 10 cycles -> m_axis_tvalid=1 and 2 beats held; s_axis_tready[1]=0 after the 2nd beat; no loss after tready returns.
//  4. q2 drops tvalid for 5 cycles mid-packet while q3 is valid -> grant stays 2 until q2's tlast, then q3 is granted.
//  5. Reset asserted on beat 2 of a 4-beat packet -> next cycle m_axis_tvalid=0, all s_axis_tready=0, rr_ptr=3; first post-reset grant goes to the lowest valid queue.
//  6. STATS_EN: 5 single-beat packets on q0 and 2 on q3 -> pkt_count q0=5, q3=2, q1=q2=0.

Source files
------------

// File: rtl/nf10_bridge_input_arbiter_pkg.sv
// ==== nf10_bridge_input_arbiter_pkg : shared FSM encodings and clog2 helper ==== rev 1.0
`default_nettype none

package nf10_bridge_input_arbiter_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_PKT  = 1'b1
  } arb_state_t;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

`default_nettype wire

// File: rtl/nf10_axis_skid_slice.sv
// ==== nf10_axis_skid_slice : 2-entry registered AXI4-Stream slice, no comb path ready->ready ==== rev 1.0
`default_nettype none

module nf10_axis_skid_slice #(
  parameter int DATA  = 256,
  parameter int TUSER = 128
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [DATA-1:0]    in_tdata,
  input  logic [DATA/8-1:0]  in_tstrb,
  input  logic [TUSER-1:0]   in_tuser,
  input  logic               in_tlast,
  input  logic               in_push,
  output logic               can_accept,
  output logic [DATA-1:0]    m_axis_tdata,
  output logic [DATA/8-1:0]  m_axis_tstrb,
  output logic [TUSER-1:0]   m_axis_tuser,
  output logic               m_axis_tvalid,
  output logic               m_axis_tlast,
  input  logic               m_axis_tready
);

  localparam int W = DATA + DATA/8 + TUSER + 1;

  logic [W-1:0] head;
  logic [W-1:0] skid;
  logic         head_valid;
  logic         skid_valid;
  logic [W-1:0] in_beat;
  logic         push;
  logic         pop;
  logic [1:0]   next_cnt;

  assign in_beat = {in_tdata, in_tstrb, in_tuser, in_tlast};
  assign push    = in_push & can_accept;
  assign pop     = head_valid & m_axis_tready;

  assign {m_axis_tdata, m_axis_tstrb, m_axis_tuser, m_axis_tlast} = head;
  assign m_axis_tvalid = head_valid;

  always_comb begin
    next_cnt = 2'(head_valid) + 2'(skid_valid) + 2'(push) - 2'(pop);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head       <= '0;
      skid       <= '0;
      head_valid <= 1'b0;
      skid_valid <= 1'b0;
      can_accept <= 1'b0;
    end else begin
      // Head is the output register; the skid entry only fills while head stalls.
      if (!head_valid || pop) begin
        if (skid_valid) begin
          head       <= skid;
          head_valid <= 1'b1;
          if (push) skid <= in_beat;
          else      skid_valid <= 1'b0;
        end else begin
          if (push) head <= in_beat;
          head_valid <= push;
        end
      end else if (push) begin
        skid       <= in_beat;
        skid_valid <= 1'b1;
      end
      can_accept <= (next_cnt != 2'd2);
    end
  end

endmodule

`default_nettype wire

// File: rtl/nf10_bridge_input_arbiter.sv
// ==== nf10_bridge_input_arbiter : packet round-robin arbiter feeding one LE->BE bridge ==== rev 1.0
// Optional per-queue packet counters via NF10_BRIDGE_ARB_STATS_EN.
`default_nettype none

module nf10_bridge_input_arbiter
  import nf10_bridge_input_arbiter_pkg::*;
#(
  parameter int C_AXIS_DATA_WIDTH  = 256,
  parameter int C_AXIS_TUSER_WIDTH = 128,
  parameter int NUM_QUEUES         = 4
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic [NUM_QUEUES*C_AXIS_DATA_WIDTH-1:0]  s_axis_tdata,
  input  logic [NUM_QUEUES*C_AXIS_DATA_WIDTH/8-1:0] s_axis_tstrb,
  input  logic [NUM_QUEUES*C_AXIS_TUSER_WIDTH-1:0] s_axis_tuser,
  input  logic [NUM_QUEUES-1:0]                    s_axis_tvalid,
  input  logic [NUM_QUEUES-1:0]                    s_axis_tlast,
  output logic [NUM_QUEUES-1:0]                    s_axis_tready,
  output logic [C_AXIS_DATA_WIDTH-1:0]             m_axis_tdata,
  output logic [C_AXIS_DATA_WIDTH/8-1:0]           m_axis_tstrb,
  output logic [C_AXIS_TUSER_WIDTH-1:0]            m_axis_tuser,
  output logic                                     m_axis_tvalid,
  output logic                                     m_axis_tlast,
  input  logic                                     m_axis_tready,
  output logic [clog2(NUM_QUEUES)-1:0]             grant_id
`ifdef NF10_BRIDGE_ARB_STATS_EN
  ,
  output logic [NUM_QUEUES*32-1:0]                 pkt_count
`endif
);

  localparam int DATA  = C_AXIS_DATA_WIDTH;
  localparam int STRB  = C_AXIS_DATA_WIDTH / 8;
  localparam int TUSER = C_AXIS_TUSER_WIDTH;
  localparam int GW    = clog2(NUM_QUEUES);

  arb_state_t        state;
  logic [GW-1:0]     rr_ptr;
  logic [GW-1:0]     pick;
  logic              slice_can_accept;
  logic [DATA-1:0]   sel_tdata;
  logic [STRB-1:0]   sel_tstrb;
  logic [TUSER-1:0]  sel_tuser;
  logic              sel_tvalid;
  logic              sel_tlast;
  logic              push;

  // First valid queue after rr_ptr, wrapping explicitly so non-power-of-2 counts work.
  always_comb begin
    logic [GW:0]   idx_wide;
    logic [GW-1:0] idx;
    logic          found;
    pick     = '0;
    found    = 1'b0;
    idx_wide = '0;
    idx      = '0;
    for (int k = 1; k <= NUM_QUEUES; k++) begin
      idx_wide = {1'b0, rr_ptr} + (GW+1)'(k);
      if (idx_wide >= (GW+1)'(NUM_QUEUES)) idx_wide = idx_wide - (GW+1)'(NUM_QUEUES);
      idx = idx_wide[GW-1:0];
      if (!found && s_axis_tvalid[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  always_comb begin
    sel_tdata  = '0;
    sel_tstrb  = '0;
    sel_tuser  = '0;
    sel_tvalid = 1'b0;
    sel_tlast  = 1'b0;
    for (int q = 0; q < NUM_QUEUES; q++) begin
      if (grant_id == GW'(q)) begin
        sel_tdata  = s_axis_tdata[q*DATA +: DATA];
        sel_tstrb  = s_axis_tstrb[q*STRB +: STRB];
        sel_tuser  = s_axis_tuser[q*TUSER +: TUSER];
        sel_tvalid = s_axis_tvalid[q];
        sel_tlast  = s_axis_tlast[q];
      end
    end
  end

  always_comb begin
    s_axis_tready = '0;
    for (int q = 0; q < NUM_QUEUES; q++) begin
      if (state == ARB_PKT && grant_id == GW'(q)) s_axis_tready[q] = slice_can_accept;
    end
  end

  assign push = (state == ARB_PKT) & sel_tvalid & slice_can_accept;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ARB_IDLE;
      grant_id <= '0;
      rr_ptr   <= GW'(NUM_QUEUES - 1);
    end else begin
      case (state)
        ARB_IDLE: begin
          if (|s_axis_tvalid) begin
            grant_id <= pick;
            state    <= ARB_PKT;
          end
        end
        ARB_PKT: begin
          if (push && sel_tlast) begin
            rr_ptr <= grant_id;
            state  <= ARB_IDLE;
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

  nf10_axis_skid_slice #(
    .DATA  (DATA),
    .TUSER (TUSER)
  ) u_slice (
    .clk           (clk),
    .reset         (reset),
    .in_tdata      (sel_tdata),
    .in_tstrb      (sel_tstrb),
    .in_tuser      (sel_tuser),
    .in_tlast      (sel_tlast),
    .in_push       (push),
    .can_accept    (slice_can_accept),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tstrb  (m_axis_tstrb),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tready (m_axis_tready)
  );

`ifdef NF10_BRIDGE_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      pkt_count <= '0;
    end else begin
      for (int q = 0; q < NUM_QUEUES; q++) begin
        if (push && sel_tlast && grant_id == GW'(q))
          pkt_count[q*32 +: 32] <= pkt_count[q*32 +: 32] + 32'd1;
      end
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_nf10_bridge_input_arbiter.sv
// ==== tb_nf10_bridge_input_arbiter : directed self-checking bench for the input arbiter ==== rev 1.0
`default_nettype none

module tb_nf10_bridge_input_arbiter;

  localparam int DW = 256;
  localparam int UW = 128;
  localparam int NQ = 4;
  localparam int SW = DW / 8;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [NQ*DW-1:0]  s_axis_tdata = '0;
  logic [NQ*SW-1:0]  s_axis_tstrb = '0;
  logic [NQ*UW-1:0]  s_axis_tuser = '0;
  logic [NQ-1:0]     s_axis_tvalid = '0;
  logic [NQ-1:0]     s_axis_tlast = '0;
  logic [NQ-1:0]     s_axis_tready;
  logic [DW-1:0]     m_axis_tdata;
  logic [SW-1:0]     m_axis_tstrb;
  logic [UW-1:0]     m_axis_tuser;
  logic              m_axis_tvalid;
  logic              m_axis_tlast;
  logic              m_axis_tready = 1'b1;
  logic [1:0]        grant_id;
`ifdef NF10_BRIDGE_ARB_STATS_EN
  logic [NQ*32-1:0]  pkt_count;
`endif

  nf10_bridge_input_arbiter #(
    .C_AXIS_DATA_WIDTH  (DW),
    .C_AXIS_TUSER_WIDTH (UW),
    .NUM_QUEUES         (NQ)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tstrb  (s_axis_tstrb),
    .s_axis_tuser  (s_axis_tuser),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tstrb  (m_axis_tstrb),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tready (m_axis_tready),
    .grant_id      (grant_id)
`ifdef NF10_BRIDGE_ARB_STATS_EN
    ,
    .pkt_count     (pkt_count)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Source model: per-queue beat lists, head index advances on handshake.
  logic [31:0]   stag  [NQ][16];
  logic          slast [NQ][16];
  int            shead [NQ];
  int            stail [NQ];
  logic [NQ-1:0] pause = '0;

  logic [DW-1:0] odata [64];
  logic [SW-1:0] ostrb [64];
  logic [UW-1:0] ouser [64];
  logic          olast [64];
  int            ocnt = 0;

  task automatic check_val(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk_tag(input int q, input int p, input int b);
    return {4'hA, 4'(q), 8'(p), 8'(b), 8'h5A};
  endfunction

  function automatic logic [DW-1:0] exp_data(input logic [31:0] t);
    return {t, ~t, t ^ 32'h5555_AAAA, {t[15:0], t[31:16]}, t, ~t, t ^ 32'h5555_AAAA, {t[15:0], t[31:16]}};
  endfunction

  function automatic logic [SW-1:0] exp_strb(input logic [31:0] t);
    return t ^ 32'h0F0F_F0F0;
  endfunction

  function automatic logic [UW-1:0] exp_user(input logic [31:0] t);
    return {~t, t, t ^ 32'h1234_5678, ~t};
  endfunction

  task automatic apply();
    logic [31:0] t;
    for (int q = 0; q < NQ; q++) begin
      if (!pause[q] && shead[q] < stail[q]) begin
        t = stag[q][shead[q]];
        s_axis_tvalid[q]          = 1'b1;
        s_axis_tlast[q]           = slast[q][shead[q]];
        s_axis_tdata[q*DW +: DW]  = exp_data(t);
        s_axis_tstrb[q*SW +: SW]  = exp_strb(t);
        s_axis_tuser[q*UW +: UW]  = exp_user(t);
      end else begin
        s_axis_tvalid[q]          = 1'b0;
        s_axis_tlast[q]           = 1'b0;
        s_axis_tdata[q*DW +: DW]  = '0;
        s_axis_tstrb[q*SW +: SW]  = '0;
        s_axis_tuser[q*UW +: UW]  = '0;
      end
    end
  endtask

  task automatic load(input int q, input int p, input int len);
    for (int b = 0; b < len; b++) begin
      stag[q][stail[q]]  = mk_tag(q, p, b);
      slast[q][stail[q]] = (b == len - 1);
      stail[q]++;
    end
  endtask

  task automatic clear_src();
    for (int q = 0; q < NQ; q++) begin
      shead[q] = 0;
      stail[q] = 0;
    end
    pause = '0;
    apply();
  endtask

  // Handshakes are sampled just before the edge; inputs change 1 time unit after it.
  task automatic step();
    logic [NQ-1:0] fire;
    fire = s_axis_tvalid & s_axis_tready;
    if (m_axis_tvalid && m_axis_tready && ocnt < 64) begin
      odata[ocnt] = m_axis_tdata;
      ostrb[ocnt] = m_axis_tstrb;
      ouser[ocnt] = m_axis_tuser;
      olast[ocnt] = m_axis_tlast;
      ocnt++;
    end
    @(posedge clk);
    #1;
    for (int q = 0; q < NQ; q++) if (fire[q]) shead[q]++;
    apply();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_src();
    step();
    step();
    reset = 1'b0;
    ocnt  = 0;
  endtask

  task automatic run_until(input int n, input int budget, input string tag);
    int c;
    c = 0;
    while (ocnt < n && c < budget) begin
      step();
      c++;
    end
    check_val({tag, "_beats"}, 256'(ocnt), 256'(n));
  endtask

  task automatic wait_head(input int q, input int n, input int budget, input string tag);
    int c;
    c = 0;
    while (shead[q] < n && c < budget) begin
      step();
      c++;
    end
    check_val({tag, "_accepted"}, 256'(shead[q]), 256'(n));
  endtask

  task automatic check_beat(input string tag, input int idx, input int q, input int p, input int b, input logic last);
    logic [31:0] t;
    t = mk_tag(q, p, b);
    check_val($sformatf("%s_b%0d_data", tag, idx), odata[idx], exp_data(t));
    check_val($sformatf("%s_b%0d_strb", tag, idx), 256'(ostrb[idx]), 256'(exp_strb(t)));
    check_val($sformatf("%s_b%0d_user", tag, idx), 256'(ouser[idx]), 256'(exp_user(t)));
    check_val($sformatf("%s_b%0d_last", tag, idx), 256'(olast[idx]), 256'(last));
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    do_reset();

    // Reset state
    check_val("rst_s_tready", 256'(s_axis_tready), 256'(0));
    check_val("rst_m_tvalid", 256'(m_axis_tvalid), 256'(0));
    check_val("rst_m_tlast",  256'(m_axis_tlast),  256'(0));
    check_val("rst_m_tdata",  m_axis_tdata,        256'(0));
    check_val("rst_m_tstrb",  256'(m_axis_tstrb),  256'(0));
    check_val("rst_m_tuser",  256'(m_axis_tuser),  256'(0));
    check_val("rst_grant",    256'(grant_id),      256'(0));

    // 1: single 3-beat packet from q0
    m_axis_tready = 1'b1;
    load(0, 0, 3);
    apply();
    check_val("t1_ready_idle", 256'(s_axis_tready), 256'(0));
    step();
    check_val("t1_grant", 256'(grant_id), 256'(0));
    check_val("t1_ready", 256'(s_axis_tready), 256'(4'b0001));
    run_until(3, 20, "t1");
    check_beat("t1", 0, 0, 0, 0, 1'b0);
    check_beat("t1", 1, 0, 0, 1, 1'b0);
    check_beat("t1", 2, 0, 0, 2, 1'b1);

    // 2: all queues request at once; round robin from rr_ptr=3
    do_reset();
    load(0, 0, 2); load(1, 0, 2); load(2, 0, 2); load(3, 0, 2); load(0, 1, 2);
    apply();
    run_until(10, 60, "t2");
    begin
      int qs [5] = '{0, 1, 2, 3, 0};
      int ps [5] = '{0, 0, 0, 0, 1};
      for (int k = 0; k < 5; k++) begin
        check_beat("t2", 2*k,     qs[k], ps[k], 0, 1'b0);
        check_beat("t2", 2*k + 1, qs[k], ps[k], 1, 1'b1);
      end
    end

    // 3: downstream stalled; slice fills with two beats then back-pressures
    do_reset();
    m_axis_tready = 1'b0;
    load(1, 0, 4);
    apply();
    repeat (12) step();
    check_val("t3_m_tvalid", 256'(m_axis_tvalid), 256'(1));
    check_val("t3_s_tready", 256'(s_axis_tready), 256'(0));
    check_val("t3_held",     256'(shead[1]),      256'(2));
    check_val("t3_grant",    256'(grant_id),      256'(1));
    m_axis_tready = 1'b1;
    run_until(4, 30, "t3");
    for (int b = 0; b < 4; b++) check_beat("t3", b, 1, 0, b, b == 3);

    // 4: q2 pauses mid-packet while q3 waits
    do_reset();
    load(2, 0, 4);
    load(3, 0, 2);
    apply();
    wait_head(2, 2, 20, "t4");
    pause[2] = 1'b1;
    apply();
    repeat (5) step();
    check_val("t4_grant_hold", 256'(grant_id),      256'(2));
    check_val("t4_ready_hold", 256'(s_axis_tready), 256'(4'b0100));
    pause[2] = 1'b0;
    apply();
    run_until(6, 40, "t4");
    for (int b = 0; b < 4; b++) check_beat("t4", b, 2, 0, b, b == 3);
    check_beat("t4", 4, 3, 0, 0, 1'b0);
    check_beat("t4", 5, 3, 0, 1, 1'b1);

    // 5: reset in the middle of a packet; pointer must return to NUM_QUEUES-1
    do_reset();
    load(1, 0, 1);
    apply();
    run_until(1, 10, "t5_pre");
    load(2, 0, 4);
    apply();
    wait_head(2, 1, 20, "t5");
    reset = 1'b1;
    step();
    check_val("t5_m_tvalid", 256'(m_axis_tvalid), 256'(0));
    check_val("t5_s_tready", 256'(s_axis_tready), 256'(0));
    check_val("t5_grant_rst", 256'(grant_id),     256'(0));
    clear_src();
    reset = 1'b0;
    ocnt  = 0;
    load(1, 1, 1);
    load(3, 0, 1);
    apply();
    step();
    check_val("t5_grant", 256'(grant_id), 256'(1));
    run_until(2, 20, "t5");
    check_beat("t5", 0, 1, 1, 0, 1'b1);
    check_beat("t5", 1, 3, 0, 0, 1'b1);

`ifdef NF10_BRIDGE_ARB_STATS_EN
    // 6: per-queue packet counters
    do_reset();
    for (int p = 0; p < 5; p++) load(0, p, 1);
    load(3, 0, 1);
    load(3, 1, 1);
    apply();
    run_until(7, 60, "t6");
    check_beat("t6", 0, 0, 0, 0, 1'b1);
    check_beat("t6", 1, 3, 0, 0, 1'b1);
    check_beat("t6", 2, 0, 1, 0, 1'b1);
    check_beat("t6", 3, 3, 1, 0, 1'b1);
    check_beat("t6", 6, 0, 4, 0, 1'b1);
    check_val("t6_cnt_q0", 256'(pkt_count[0*32 +: 32]), 256'(5));
    check_val("t6_cnt_q1", 256'(pkt_count[1*32 +: 32]), 256'(0));
    check_val("t6_cnt_q2", 256'(pkt_count[2*32 +: 32]), 256'(0));
    check_val("t6_cnt_q3", 256'(pkt_count[3*32 +: 32]), 256'(2));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
